// File: rtl/csa_final_adder_pkg.sv
// Shared definitions for the carry-save final adder: state encoding and chunking helpers.
package csa_final_adder_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAdd  = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic int unsigned nchunk_f(input int unsigned bits, input int unsigned chunk);
        return (2 * bits) / chunk;
    endfunction

    // The index register needs at least one bit, even when there is a single chunk.
    function automatic int unsigned idx_width_f(input int unsigned nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/csa_chunk_add.sv
// Combinational CHUNK-bit adder with carry in and carry out.
module csa_chunk_add #(
    parameter int unsigned CHUNK = 16
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, cin_i};

endmodule

// File: rtl/csa_final_adder.sv
// Resolves a carry-save (z, c) pair into z + c, CHUNK bits per cycle with a registered carry.
module csa_final_adder
    import csa_final_adder_pkg::*;
#(
    parameter int unsigned bits   = 32,
    parameter int unsigned CHUNK  = 16,
    parameter int unsigned NCHUNK = nchunk_f(bits, CHUNK)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*bits-1:0] z,
    input  logic [2*bits-1:0] c,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*bits-1:0] p,
    output logic              busy
);

    localparam int unsigned W  = 2 * bits;
    localparam int unsigned IW = idx_width_f(NCHUNK);
    localparam logic [IW-1:0] LastIdx = IW'(NCHUNK - 1);

    if ((W % CHUNK) != 0) begin : g_bad_chunk
        $error("csa_final_adder: 2*bits must be a multiple of CHUNK");
    end
    if (NCHUNK != W / CHUNK) begin : g_bad_nchunk
        $error("csa_final_adder: NCHUNK is derived and must not be overridden");
    end

    state_e         state_q;
    logic [W-1:0]   z_q, c_q, p_q;
    logic [IW-1:0]  idx_q;
    logic           carry_q;
    logic           out_valid_q;
    logic           busy_q;

    logic [CHUNK-1:0] a_sel, b_sel, sum;
    logic             cout;

    // Select operand chunk k = idx_q for the single shared adder.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int unsigned k = 0; k < NCHUNK; k++) begin
            if (idx_q == IW'(k)) begin
                a_sel = z_q[k*CHUNK +: CHUNK];
                b_sel = c_q[k*CHUNK +: CHUNK];
            end
        end
    end

    csa_chunk_add #(
        .CHUNK (CHUNK)
    ) u_chunk_add (
        .a_i    (a_sel),
        .b_i    (b_sel),
        .cin_i  (carry_q),
        .sum_o  (sum),
        .cout_o (cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            z_q         <= '0;
            c_q         <= '0;
            p_q         <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        z_q     <= z;
                        c_q     <= c;
                        carry_q <= 1'b0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StAdd;
                    end
                end
                StAdd: begin
                    for (int unsigned k = 0; k < NCHUNK; k++) begin
                        if (idx_q == IW'(k)) begin
                            p_q[k*CHUNK +: CHUNK] <= sum;
                        end
                    end
                    // Carry out of the top chunk lands here and is never used.
                    carry_q <= cout;
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == LastIdx) begin
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = out_valid_q;
    assign p         = p_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_csa_final_adder.sv
// Self-checking bench for csa_final_adder: directed corner cases plus a randomized queue model.
module tb_csa_final_adder;

    localparam int unsigned BITS   = 32;
    localparam int unsigned CHUNK  = 16;
    localparam int unsigned NCH    = (2 * BITS) / CHUNK;
    localparam int unsigned NRAND  = 1000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [2*BITS-1:0] z = '0;
    logic [2*BITS-1:0] c = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [2*BITS-1:0] p;
    logic              busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    csa_final_adder #(
        .bits  (BITS),
        .CHUNK (CHUNK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .z         (z),
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one pair, waits for the handshake, then counts cycles until out_valid.
    task automatic do_txn(input logic [63:0] zz, input logic [63:0] cc, output int lat);
        int w;
        z = zz;
        c = cc;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        tick();
        in_valid = 1'b0;
        z = rand64();
        c = rand64();
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        z = 64'h1234;
        c = 64'h1;
        tick();
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        n_vec++;
        if (p !== 64'h0) begin
            n_err++;
            $display("FAIL reset_p: got %h want 0", p);
        end
        n_vec++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_flags: got busy=%b in_ready=%b want busy=0 in_ready=1", busy, in_ready);
        end
        tick();
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ignores_valid: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_ripple();
        int lat;
        logic [63:0] zz = 64'h0000_0000_FFFF_FFFF;
        logic [63:0] cc = 64'h1;
        do_txn(zz, cc, lat);
        n_vec++;
        if (lat != NCH) begin
            n_err++;
            $display("FAIL ripple_latency: got %0d want %0d", lat, NCH);
        end
        n_vec++;
        if (p !== 64'h0000_0001_0000_0000) begin
            n_err++;
            $display("FAIL ripple_p: got %h want %h", p, 64'h0000_0001_0000_0000);
        end
        n_vec++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL ripple_done_flags: got busy=%b in_ready=%b want 1 0", busy, in_ready);
        end
        drain();
    endtask

    task automatic test_wrap();
        int lat;
        do_txn(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, lat);
        n_vec++;
        if (out_valid !== 1'b1 || lat != NCH) begin
            n_err++;
            $display("FAIL wrap_valid: got out_valid=%b lat=%0d want 1 %0d", out_valid, lat, NCH);
        end
        n_vec++;
        if (p !== 64'h0) begin
            n_err++;
            $display("FAIL wrap_p: got %h want 0", p);
        end
        drain();
    endtask

    task automatic test_compressor();
        int lat;
        logic [63:0] x1 = 64'd3, x2 = 64'd5, x3 = 64'd7;
        logic [63:0] zz, cc;
        zz = x1 ^ x2 ^ x3;
        cc = ((x1 & x2) | (x1 & x3) | (x2 & x3)) << 1;
        do_txn(zz, cc, lat);
        n_vec++;
        if (p !== x1 + x2 + x3) begin
            n_err++;
            $display("FAIL compressor_p: got %h want %h", p, x1 + x2 + x3);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [63:0] zz = 64'hDEAD_BEEF_0123_4567;
        logic [63:0] cc = 64'h1111_2222_FEDC_BA98;
        do_txn(zz, cc, lat);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            z = rand64();
            c = rand64();
            tick();
            n_vec++;
            if (p !== zz + cc || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL backpressure_hold[%0d]: got p=%h ov=%b ir=%b want p=%h ov=1 ir=0",
                         i, p, out_valid, in_ready, zz + cc);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL backpressure_no_same_cycle: got in_ready=%b want 0", in_ready);
        end
        tick();
        out_ready = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL backpressure_release: got ov=%b ir=%b busy=%b want 0 1 0",
                     out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset_mid_add();
        int lat;
        logic [63:0] zz = 64'h0F0F_F0F0_AAAA_5555;
        logic [63:0] cc = 64'h7777_8888_5555_AAAB;
        z = zz;
        c = cc;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || p !== 64'h0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_add: got ov=%b p=%h busy=%b ir=%b want 0 0 0 1",
                     out_valid, p, busy, in_ready);
        end
        do_txn(cc, zz ^ cc, lat);
        n_vec++;
        if (p !== cc + (zz ^ cc) || lat != NCH) begin
            n_err++;
            $display("FAIL after_reset_txn: got p=%h lat=%0d want p=%h lat=%0d",
                     p, lat, cc + (zz ^ cc), NCH);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_q[$];
        logic [63:0] want;
        int sent = 0, recvd = 0, cycles = 0;
        bit accepted;
        while (recvd < NRAND && cycles < NRAND * 20) begin
            if (!in_valid && sent < NRAND && $urandom_range(3) != 0) begin
                z = rand64();
                c = ($urandom_range(3) == 0) ? ~z + 64'($urandom_range(2)) : rand64();
                in_valid = 1'b1;
            end
            out_ready = 1'($urandom_range(1));
            accepted = 1'b0;
            if (in_valid && in_ready) begin
                exp_q.push_back(z + c);
                sent++;
                accepted = 1'b1;
            end
            if (out_valid && out_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL random_extra_result: got %h with nothing outstanding", p);
                end else begin
                    want = exp_q.pop_front();
                    if (p !== want) begin
                        n_err++;
                        $display("FAIL random_p[%0d]: got %h want %h", recvd, p, want);
                    end
                end
                recvd++;
            end
            tick();
            if (accepted) begin
                in_valid = 1'b0;
                z = rand64();
                c = rand64();
            end
            cycles++;
        end
        out_ready = 1'b0;
        in_valid = 1'b0;
        n_vec++;
        if (recvd != NRAND || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL random_count: got %0d results (%0d pending) want %0d",
                     recvd, exp_q.size(), NRAND);
        end
    endtask

    initial begin
        test_reset();
        test_ripple();
        test_wrap();
        test_compressor();
        test_backpressure();
        test_reset_mid_add();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
